// File: rtl/serial_add_pkg.sv
// Shared types and default geometry for the slice-serial adder.
// Default operand width is 64 bits, processed as eight 8-bit chunks.
package serial_add_pkg;

    localparam int DEF_W = 64;
    localparam int DEF_S = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl; master drives operands and io_out_ready.
// Build with SERIAL_ADD_OVF_EN to carry the signed-overflow flag alongside the result.
interface serial_add_ctrl_if #(
    parameter int W = serial_add_pkg::DEF_W
);
    logic         io_in_valid;
    logic         io_in_ready;
    logic [W-1:0] io_in_a;
    logic [W-1:0] io_in_b;
    logic         io_in_c;
    logic         io_out_valid;
    logic         io_out_ready;
    logic [W-1:0] io_out_sum;
    logic         io_out_c_out;
`ifdef SERIAL_ADD_OVF_EN
    logic         io_out_ovf;
`endif

    modport master (
        output io_in_valid, io_in_a, io_in_b, io_in_c, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_sum, io_out_c_out
`ifdef SERIAL_ADD_OVF_EN
        , input io_out_ovf
`endif
    );

    modport slave (
        input  io_in_valid, io_in_a, io_in_b, io_in_c, io_out_ready,
        output io_in_ready, io_out_valid, io_out_sum, io_out_c_out
`ifdef SERIAL_ADD_OVF_EN
        , output io_out_ovf
`endif
    );

endinterface

// File: rtl/cla_slice.sv
// Combinational S-bit carry-lookahead adder slice with group propagate/generate.
// Zero latency; no handshake.
module cla_slice #(
    parameter int S = serial_add_pkg::DEF_S
) (
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    input  logic         c_in,
    output logic [S-1:0] sum,
    output logic         c_out,
    output logic         p_grp,
    output logic         g_grp
);

    logic [S-1:0] p;
    logic [S-1:0] g;
    logic [S:0]   carry;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is the flattened lookahead term: OR of every generate
    // propagated up to bit i, plus c_in propagated through all lower bits.
    always_comb begin : lookahead
        logic pp;
        logic acc;
        pp    = 1'b1;
        acc   = 1'b0;
        carry = '0;
        carry[0] = c_in;
        for (int i = 0; i < S; i++) begin
            pp  = 1'b1;
            acc = 1'b0;
            for (int j = i; j >= 0; j--) begin
                acc = acc | (g[j] & pp);
                pp  = pp & p[j];
            end
            carry[i+1] = acc | (pp & c_in);
        end
        g_grp = acc;
        p_grp = pp;
    end

    assign sum   = p ^ carry[S-1:0];
    assign c_out = carry[S];

endmodule

// File: rtl/serial_add_ctrl.sv
// W-bit adder built from one reused S-bit slice; result valid N=W/S cycles after accept, one result per N+1 cycles back-to-back.
// Result is held until io_out_ready; a new operand set is taken in IDLE or on the handoff edge. Optional SERIAL_ADD_OVF_EN adds io_out_ovf.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int S = DEF_S
) (
    input  logic              clock,
    input  logic              reset,
    serial_add_ctrl_if.slave  io
);

    localparam int N  = W / S;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  sum_q;
    logic          c_out_q;
    logic          valid_q;

    logic [S-1:0]  sl_a;
    logic [S-1:0]  sl_b;
    logic [S-1:0]  sl_sum;
    logic          sl_cout;
    logic          sl_p;
    logic          sl_g;
    logic          accept;
    logic          last;

    assign io.io_in_ready = (state_q == IDLE) || ((state_q == DONE) && io.io_out_ready);
    assign accept         = io.io_in_valid && io.io_in_ready;
    assign last           = (idx_q == IW'(N - 1));

    assign sl_a = a_q[int'(idx_q) * S +: S];
    assign sl_b = b_q[int'(idx_q) * S +: S];

    cla_slice #(.S(S)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .c_in  (carry_q),
        .sum   (sl_sum),
        .c_out (sl_cout),
        .p_grp (sl_p),
        .g_grp (sl_g)
    );

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;
    logic msb_cin;

    // Carry into bit W-1 recovered from the top slice's MSB sum bit.
    assign msb_cin       = sl_a[S-1] ^ sl_b[S-1] ^ sl_sum[S-1];
    assign io.io_out_ovf = ovf_q;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            valid_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (accept) begin
            // Covers both a fresh start from IDLE and the DONE handoff edge.
            state_q <= RUN;
            idx_q   <= '0;
            carry_q <= io.io_in_c;
            a_q     <= io.io_in_a;
            b_q     <= io.io_in_b;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            valid_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                RUN: begin
                    sum_q[int'(idx_q) * S +: S] <= sl_sum;
                    carry_q <= sl_cout;
                    if (last) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                        c_out_q <= sl_g | (sl_p & carry_q);
`ifdef SERIAL_ADD_OVF_EN
                        ovf_q   <= msb_cin ^ sl_cout;
`endif
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    if (io.io_out_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                IDLE: ;
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign io.io_out_valid = valid_q;
    assign io.io_out_sum   = sum_q;
    assign io.io_out_c_out = c_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at W=16, S=4: directed corner cases then a random stream against an arithmetic model.
module tb_serial_add_ctrl;

    localparam int W = 16;
    localparam int S = 4;
    localparam int N = W / S;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
    } op_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.W(W)) bus ();

    serial_add_ctrl #(.W(W), .S(S)) dut (
        .clock (clk),
        .reset (rst_n),
        .io    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W-1:0] s;
        s = a + b + {{(W-1){1'b0}}, c};
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input op_t op);
        logic [W:0] e;
        e = ref_add(op.a, op.b, op.c);
        chk({tag, "_sum"},  bus.io_out_sum,   e[W-1:0]);
        chk({tag, "_cout"}, bus.io_out_c_out, e[W]);
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, "_ovf"},  bus.io_out_ovf,   ref_ovf(op.a, op.b, op.c));
`endif
    endtask

    // Called just after the accepting edge; counts edges until io_out_valid.
    task automatic wait_result(input string tag, input op_t op);
        logic [W:0] e;
        int lat;
        e   = ref_add(op.a, op.b, op.c);
        lat = 0;
        while (bus.io_out_valid !== 1'b1 && lat < 20) begin
            if (lat == 2)
                chk({tag, "_partial"}, bus.io_out_sum, e[W-1:0] & W'((1 << (2 * S)) - 1));
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, N);
        check_result(tag, op);
    endtask

    task automatic start_op(input string tag, input op_t op);
        bus.io_in_a      = op.a;
        bus.io_in_b      = op.b;
        bus.io_in_c      = op.c;
        bus.io_in_valid  = 1'b1;
        bus.io_out_ready = 1'b0;
        #1;
        chk({tag, "_in_rdy"}, bus.io_in_ready, 1'b1);
        tick();
        bus.io_in_valid = 1'b0;
        bus.io_in_a     = W'($urandom);
        bus.io_in_b     = W'($urandom);
        bus.io_in_c     = 1'($urandom);
        wait_result(tag, op);
    endtask

    task automatic consume(input string tag);
        bus.io_out_ready = 1'b1;
        tick();
        chk({tag, "_drained"}, bus.io_out_valid, 1'b0);
        bus.io_out_ready = 1'b0;
    endtask

    initial begin
        op_t  op;
        op_t  cur;
        op_t  q[$];
        int   sent;
        int   got;
        int   cyc;
        logic [W-1:0] hold_sum;

        rst_n            = 1'b0;
        bus.io_in_valid  = 1'b0;
        bus.io_in_a      = '0;
        bus.io_in_b      = '0;
        bus.io_in_c      = 1'b0;
        bus.io_out_ready = 1'b0;
        #2;
        chk("rst_in_ready",  bus.io_in_ready,  1'b1);
        chk("rst_out_valid", bus.io_out_valid, 1'b0);
        chk("rst_sum",       bus.io_out_sum,   '0);
        chk("rst_cout",      bus.io_out_c_out, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf",       bus.io_out_ovf,   1'b0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        op = '{a: 16'h1234, b: 16'h1111, c: 1'b0};
        start_op("basic", op);
        chk("basic_const", bus.io_out_sum, 16'h2345);
        consume("basic");

        op = '{a: 16'hFFFF, b: 16'h0000, c: 1'b1};
        start_op("ripple", op);
        chk("ripple_const", bus.io_out_sum, 16'h0000);
        consume("ripple");

        op = '{a: 16'h7FFF, b: 16'h0001, c: 1'b0};
        start_op("ovf", op);
        chk("ovf_const", bus.io_out_sum, 16'h8000);
        consume("ovf");

        op = '{a: W'($urandom), b: W'($urandom), c: 1'($urandom)};
        start_op("stall", op);
        hold_sum = ref_add(op.a, op.b, op.c);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", bus.io_out_valid, 1'b1);
            chk("stall_sum",   bus.io_out_sum,   hold_sum);
            chk("stall_in_rdy", bus.io_in_ready, 1'b0);
        end
        op = '{a: 16'h0001, b: 16'h0002, c: 1'b0};
        bus.io_in_a      = op.a;
        bus.io_in_b      = op.b;
        bus.io_in_c      = op.c;
        bus.io_in_valid  = 1'b1;
        bus.io_out_ready = 1'b1;
        #1;
        chk("handoff_in_rdy", bus.io_in_ready, 1'b1);
        tick();
        bus.io_in_valid  = 1'b0;
        bus.io_out_ready = 1'b0;
        chk("handoff_valid_drop", bus.io_out_valid, 1'b0);
        wait_result("handoff", op);
        chk("handoff_const", bus.io_out_sum, 16'h0003);
        consume("handoff");

        bus.io_in_a     = 16'hABCD;
        bus.io_in_b     = 16'h1357;
        bus.io_in_c     = 1'b1;
        bus.io_in_valid = 1'b1;
        tick();
        bus.io_in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid",  bus.io_out_valid, 1'b0);
        chk("midrst_sum",    bus.io_out_sum,   '0);
        chk("midrst_in_rdy", bus.io_in_ready,  1'b1);
        tick();
        rst_n = 1'b1;
        bus.io_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("midrst_no_stale", bus.io_out_valid, 1'b0);
        end
        bus.io_out_ready = 1'b0;

        sent = 0;
        got  = 0;
        cyc  = 0;
        cur  = '{a: '0, b: '0, c: 1'b0};
        while (got < 1000 && cyc < 40000) begin
            if (!bus.io_in_valid) begin
                if (sent < 1000 && $urandom_range(0, 4) != 0) begin
                    cur = '{a: W'($urandom), b: W'($urandom), c: 1'($urandom)};
                    bus.io_in_a     = cur.a;
                    bus.io_in_b     = cur.b;
                    bus.io_in_c     = cur.c;
                    bus.io_in_valid = 1'b1;
                end else begin
                    bus.io_in_a = W'($urandom);
                    bus.io_in_b = W'($urandom);
                    bus.io_in_c = 1'($urandom);
                end
            end
            bus.io_out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (bus.io_out_valid && bus.io_out_ready) begin
                if (q.size() != 0) begin
                    op = q.pop_front();
                    check_result("rnd", op);
                end else begin
                    chk("rnd_unexpected_valid", bus.io_out_valid, 1'b0);
                end
                got++;
            end
            if (bus.io_in_valid && bus.io_in_ready) begin
                q.push_back(cur);
                sent++;
                tick();
                bus.io_in_valid = 1'b0;
            end else begin
                tick();
            end
            cyc++;
        end
        chk("rnd_count",   got,      1000);
        chk("rnd_sent",    sent,     1000);
        chk("rnd_q_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter W, default 64: total operand width; SHALL be a multiple of S.
REQ-002 Parameter S, default 8: slice width of the adder reused each cycle; N = W/S chunks.
REQ-003 clock  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 io_in_valid  input  1  operand set offered.
REQ-006 io_in_ready  output  1  block can accept an operand set this cycle.
REQ-007 io_in_a  input  W  addend A.
REQ-008 io_in_b  input  W  addend B.
REQ-009 io_in_c  input  1  carry-in.
REQ-010 io_out_valid  output  1  result available.
REQ-011 io_out_ready  input  1  consumer takes the result.
REQ-012 io_out_sum  output  W  A+B+c_in, mod 2^W.
REQ-013 io_out_c_out  output  1  carry out of bit W-1.

Function
REQ-014 FSM SHALL have states IDLE, RUN, DONE; encoded via the shared package enum.
REQ-015 io_in_ready SHALL be 1 in IDLE, 1 in DONE when io_out_ready=1, else 0.
REQ-016 Accept (io_in_valid & io_in_ready at an edge) SHALL register A, B, c_in, clear chunk index to 0, and go to RUN.
REQ-017 Each RUN cycle SHALL add chunk[idx] of A and B plus the carry register in one S-bit slice, write the S-bit sum into io_out_sum bits [idx*S +: S], load the slice carry-out into the carry register, and increment idx.
REQ-018 On the edge processing idx = N-1, the FSM SHALL go to DONE; idx wrap-around beyond N-1 SHALL never occur.
REQ-019 Latency: io_out_valid SHALL rise exactly N cycles after the accepting edge (W=64, S=8: 8 cycles).
REQ-020 io_out_valid SHALL be 1 only in DONE; io_out_sum and io_out_c_out SHALL hold stable while io_out_valid=1 and io_out_ready=0.
REQ-021 DONE with io_out_ready=1 and io_in_valid=0 SHALL go to IDLE.
REQ-022 DONE with io_out_ready=1 and io_in_valid=1 SHALL hand off the result and accept the new set in the same edge, going directly to RUN (back-to-back throughput: one result per N+1 cycles).
REQ-023 io_in_* SHALL be ignored in RUN; operands are sampled only on accept.
REQ-024 io_out_sum bits for chunks not yet processed SHALL be 0 during RUN (cleared on accept).

Reset
REQ-025 reset low SHALL immediately force IDLE, idx=0, carry=0, io_out_sum=0, io_out_c_out=0, io_out_valid=0; io_in_ready=1.
REQ-026 reset asserted mid-RUN or in DONE SHALL discard the operation with no result ever presented.

Configuration
REQ-027 Macro SERIAL_ADD_OVF_EN defined: port io_out_ovf (output 1) SHALL exist, equal to two's-complement signed overflow (carry into bit W-1 XOR carry out), valid and held under the same rules as io_out_sum, reset 0.
REQ-028 Macro undefined: io_out_ovf and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package serial_add_pkg SHALL hold the state enum typedef and default W/S constants.
REQ-030 One sub-module cla_slice (combinational S-bit carry-lookahead slice: a, b, c_in -> sum, c_out, plus group p/g) SHALL be instantiated once and reused every RUN cycle.

Verification (W=16, S=4, N=4 unless noted)
REQ-031 Reset released, A=0x1234, B=0x1111, c_in=0 accepted -> io_out_valid rises 4 cycles later, sum=0x2345, c_out=0.
REQ-032 A=0xFFFF, B=0x0000, c_in=1 -> carry ripples through all 4 chunks: sum=0x0000, c_out=1; with SERIAL_ADD_OVF_EN, ovf=0.
REQ-033 A=0x7FFF, B=0x0001, c_in=0, SERIAL_ADD_OVF_EN -> sum=0x8000, c_out=0, ovf=1.
REQ-034 io_out_ready held 0 for 5 cycles in DONE -> sum/c_out stable, io_in_ready=0; then io_out_ready=1 with io_in_valid=1 (A=1,B=2) -> handoff and accept same edge, next result 0x0003 after 4 cycles.
REQ-035 reset asserted during RUN idx=2 -> next cycle io_out_valid=0, sum=0, io_in_ready=1; no stale result after release.
REQ-036 Random back-to-back stream, 1000 ops, random io_out_ready stalls -> every result matches A+B+c_in model, order preserved, none dropped or duplicated.
